// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial bit-pattern detector with runtime pattern, overlap mode and saturating match counter
module seq_pattern_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat,
    input  logic             overlap,
    input  logic             clr_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ARMED
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_W-1:0]   pat_reg;
    logic [PAT_W-1:0]   hist, hist_nxt;
    logic [PAT_W-1:0]   shifted;
    logic [FILL_W-1:0]  fill, fill_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               accept;
    logic               hit;

    assign shifted = {hist[PAT_W-2:0], in};
    assign accept  = in_valid && !pat_load && (state != IDLE);
    // In FILL the history only becomes comparable once this bit completes it.
    assign hit     = accept && (shifted == pat_reg) &&
                     ((state == ARMED) || (fill == FILL_W'(PAT_W - 1)));

    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill;
        if (pat_load) begin
            state_nxt = FILL;
            hist_nxt  = '0;
            fill_nxt  = '0;
        end else if (accept) begin
            hist_nxt = shifted;
            if (hit && !overlap) begin
                state_nxt = FILL;
                hist_nxt  = '0;
                fill_nxt  = '0;
            end else if (state == FILL) begin
                fill_nxt = fill + FILL_W'(1);
                if (fill == FILL_W'(PAT_W - 1)) begin
                    state_nxt = ARMED;
                end
            end
        end
    end

    always_comb begin
        count_nxt = match_count;
        if (clr_count) begin
            count_nxt = hit ? CNT_W'(1) : '0;
        end else if (hit && !count_sat) begin
            count_nxt = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pat_reg     <= '0;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            state       <= state_nxt;
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            match       <= hit;
            match_count <= count_nxt;
            count_sat   <= &count_nxt;
            if (pat_load) begin
                pat_reg <= pat;
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_b, pat_load, overlap, clr_count;
    logic [3:0] pat;
    logic       m8, s8, m2, s2;
    logic [7:0] c8;
    logic [1:0] c2;

    int n_cmp = 0;
    int n_err = 0;

    int      q[$];
    bit      loaded;
    bit [3:0] mpat;
    bit      e_match;
    int      e_c8, e_c2;

    seq_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
        .pat_load(pat_load), .pat(pat), .overlap(overlap), .clr_count(clr_count),
        .match(m8), .match_count(c8), .count_sat(s8)
    );

    seq_pattern_detector #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
        .pat_load(pat_load), .pat(pat), .overlap(overlap), .clr_count(clr_count),
        .match(m2), .match_count(c2), .count_sat(s2)
    );

    always #5 clk = ~clk;

    // Reference: remembers the accepted bits since the last restart and looks at the newest four.
    task automatic step(input bit v, input bit b, input bit ld, input bit [3:0] p,
                        input bit ov, input bit clr);
        bit hit;
        int w;
        in_valid = v; in_b = b; pat_load = ld; pat = p; overlap = ov; clr_count = clr;
        @(posedge clk);
        hit = 1'b0;
        if (ld) begin
            loaded = 1'b1;
            mpat = p;
            q.delete();
        end else if (v && loaded) begin
            q.push_back(int'(b));
            if (q.size() >= 4) begin
                w = 0;
                for (int i = q.size() - 4; i < q.size(); i++) w = (w << 1) | q[i];
                hit = (w == int'(mpat));
            end
            if (hit && !ov) q.delete();
            while (q.size() > 4) void'(q.pop_front());
        end
        e_match = hit;
        if (clr) begin
            e_c8 = int'(hit);
            e_c2 = int'(hit);
        end else begin
            if (hit && e_c8 < 255) e_c8++;
            if (hit && e_c2 < 3) e_c2++;
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        loaded = 1'b0;
        e_match = 1'b0;
        e_c8 = 0;
        e_c2 = 0;
    endtask

    task automatic do_reset();
        in_valid = 0; in_b = 0; pat_load = 0; pat = 0; overlap = 0; clr_count = 0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (m8 !== 1'b0) begin n_err++; $display("FAIL reset_match got %b want 0", m8); end
        n_cmp++; if (c8 !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", c8); end
        n_cmp++; if (s8 !== 1'b0) begin n_err++; $display("FAIL reset_sat got %b want 0", s8); end
        n_cmp++; if (c2 !== 2'd0) begin n_err++; $display("FAIL reset_count2 got %0d want 0", c2); end
        n_cmp++; if (s2 !== 1'b0) begin n_err++; $display("FAIL reset_sat2 got %b want 0", s2); end
    endtask

    task automatic test_mixed(input bit ov, input bit [6:0] expv, input int exp_cnt);
        bit [6:0] bits;
        bits = 7'b1011011;
        do_reset();
        step(0, 0, 1, 4'b1011, ov, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, bits[6-i], 0, 4'b1011, ov, 0);
            n_cmp++;
            if (m8 !== expv[6-i]) begin
                n_err++; $display("FAIL mixed_ov%0d_bit%0d match got %b want %b", ov, i + 1, m8, expv[6-i]);
            end
        end
        n_cmp++;
        if (c8 !== 8'(exp_cnt)) begin n_err++; $display("FAIL mixed_ov%0d_count got %0d want %0d", ov, c8, exp_cnt); end
    endtask

    task automatic test_nonoverlap_fill();
        test_mixed(1'b0, 7'b0001000, 1);
        n_cmp++; if (dut8.fill !== 3'd3) begin n_err++; $display("FAIL nonoverlap_fill got %0d want 3", dut8.fill); end
    endtask

    task automatic test_sat_clear();
        bit [5:0] ev;
        do_reset();
        step(0, 0, 1, 4'b1111, 1, 0);
        ev = 6'b000111;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 4'b1111, 1, 0);
            n_cmp++; if (m8 !== ev[5-i]) begin n_err++; $display("FAIL ones_ov_bit%0d got %b want %b", i + 1, m8, ev[5-i]); end
        end
        n_cmp++; if (c2 !== 2'd3) begin n_err++; $display("FAIL sat_count2 got %0d want 3", c2); end
        n_cmp++; if (s2 !== 1'b1) begin n_err++; $display("FAIL sat_flag2 got %b want 1", s2); end
        n_cmp++; if (s8 !== 1'b0) begin n_err++; $display("FAIL sat_flag8 got %b want 0", s8); end
        step(1, 1, 0, 4'b1111, 1, 0);
        n_cmp++; if (c2 !== 2'd3) begin n_err++; $display("FAIL sat_hold2 got %0d want 3", c2); end
        n_cmp++; if (c8 !== 8'd4) begin n_err++; $display("FAIL sat_count8 got %0d want 4", c8); end
        step(0, 0, 1, 4'b1111, 0, 0);
        ev = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 4'b1111, 0, 0);
            n_cmp++; if (m8 !== ev[5-i]) begin n_err++; $display("FAIL ones_nov_bit%0d got %b want %b", i + 1, m8, ev[5-i]); end
        end
        step(0, 0, 1, 4'b1111, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4'b1111, 1, 0);
        step(1, 1, 0, 4'b1111, 1, 1);
        n_cmp++; if (m8 !== 1'b1) begin n_err++; $display("FAIL clr_hit_match got %b want 1", m8); end
        n_cmp++; if (c8 !== 8'd1) begin n_err++; $display("FAIL clr_hit_count got %0d want 1", c8); end
        n_cmp++; if (c2 !== 2'd1) begin n_err++; $display("FAIL clr_hit_count2 got %0d want 1", c2); end
        n_cmp++; if (s2 !== 1'b0) begin n_err++; $display("FAIL clr_hit_sat2 got %b want 0", s2); end
    endtask

    task automatic test_gaps_idle();
        bit [3:0] bits;
        int hits;
        bits = 4'b1011;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, bits[3 - (i % 4)], 0, 4'b1011, 1, 0);
            n_cmp++; if (m8 !== 1'b0) begin n_err++; $display("FAIL idle_bit%0d match got %b want 0", i, m8); end
        end
        n_cmp++; if (dut8.fill !== 3'd0) begin n_err++; $display("FAIL idle_fill got %0d want 0", dut8.fill); end
        step(0, 0, 1, 4'b1011, 1, 0);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, bits[3-i], 0, 4'b1011, 1, 0);
            n_cmp++; if (m8 !== (i == 3)) begin n_err++; $display("FAIL gap_bit%0d match got %b want %b", i + 1, m8, i == 3); end
            hits += int'(m8);
            for (int g = 0; g < 3; g++) begin
                step(0, 1, 0, 4'b1011, 1, 0);
                n_cmp++; if (m8 !== 1'b0) begin n_err++; $display("FAIL gap_idle%0d_%0d match got %b want 0", i, g, m8); end
            end
        end
        n_cmp++; if (hits != 1) begin n_err++; $display("FAIL gap_hits got %0d want 1", hits); end
    endtask

    task automatic test_load_priority();
        bit [3:0] pre, post, ev;
        do_reset();
        step(0, 0, 1, 4'b1011, 1, 0);
        pre = 4'b1011;
        for (int i = 0; i < 4; i++) step(1, pre[3-i], 0, 4'b1011, 1, 0);
        step(1, 1, 0, 4'b1011, 1, 0);
        step(1, 0, 0, 4'b1011, 1, 0);
        step(1, 1, 1, 4'b1011, 1, 0);
        n_cmp++; if (m8 !== 1'b0) begin n_err++; $display("FAIL load_drop match got %b want 0", m8); end
        post = 4'b1011; ev = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step(1, post[3-i], 0, 4'b1011, 1, 0);
            n_cmp++; if (m8 !== ev[3-i]) begin n_err++; $display("FAIL load_new_bit%0d got %b want %b", i + 1, m8, ev[3-i]); end
        end
        n_cmp++; if (c8 !== 8'd2) begin n_err++; $display("FAIL load_count got %0d want 2", c8); end
    endtask

    task automatic test_reset_mid();
        bit [9:0] bits;
        bits = 10'b1011011011;
        do_reset();
        step(0, 0, 1, 4'b1011, 1, 0);
        for (int i = 0; i < 10; i++) step(1, bits[9-i], 0, 4'b1011, 1, 0);
        n_cmp++; if (m8 !== 1'b1) begin n_err++; $display("FAIL mid_pre_match got %b want 1", m8); end
        n_cmp++; if (s2 !== 1'b1) begin n_err++; $display("FAIL mid_pre_sat2 got %b want 1", s2); end
        reset = 1'b1;
        #1;
        n_cmp++; if (m8 !== 1'b0) begin n_err++; $display("FAIL mid_async_match got %b want 0", m8); end
        n_cmp++; if (c8 !== 8'd0) begin n_err++; $display("FAIL mid_async_count got %0d want 0", c8); end
        n_cmp++; if (s2 !== 1'b0) begin n_err++; $display("FAIL mid_async_sat2 got %b want 0", s2); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1, bits[9-i], 0, 4'b1011, 1, 0);
            n_cmp++; if (m8 !== 1'b0) begin n_err++; $display("FAIL mid_noload_bit%0d got %b want 0", i, m8); end
        end
    endtask

    task automatic test_random();
        bit ld, v, b, ov, clr;
        bit [3:0] p;
        do_reset();
        ov = 1'b1;
        p = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            ld  = (i == 0) || ($urandom % 40 == 0);
            if (ld) p = 4'($urandom);
            if ($urandom % 50 == 0) ov = ~ov;
            v   = ($urandom % 4) != 0;
            b   = 1'($urandom);
            clr = ($urandom % 60) == 0;
            step(v, b, ld, p, ov, clr);
            n_cmp++; if (m8 !== e_match) begin n_err++; $display("FAIL rnd%0d match got %b want %b", i, m8, e_match); end
            n_cmp++; if (c8 !== 8'(e_c8)) begin n_err++; $display("FAIL rnd%0d count got %0d want %0d", i, c8, e_c8); end
            n_cmp++; if (s8 !== (e_c8 == 255)) begin n_err++; $display("FAIL rnd%0d sat got %b want %b", i, s8, e_c8 == 255); end
            n_cmp++; if (c2 !== 2'(e_c2)) begin n_err++; $display("FAIL rnd%0d count2 got %0d want %0d", i, c2, e_c2); end
            n_cmp++; if (s2 !== (e_c2 == 3)) begin n_err++; $display("FAIL rnd%0d sat2 got %b want %b", i, s2, e_c2 == 3); end
        end
    endtask

    initial begin
        test_reset();
        test_mixed(1'b1, 7'b0001001, 2);
        test_nonoverlap_fill();
        test_sat_clear();
        test_gaps_idle();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
